rtype_sequencer: RTL and testbench

Multi-cycle controller that owns the 32×64-bit register file and sequences R-type instructions through the 64-bit ALU. Instructions arrive over a valid/ready handshake and are processed in four steps: fetch-latch, decode, execute, writeback. Each retired instruction produces a completion pulse carrying its destination and result. A preload port initialises registers between instructions, and a combinational debug read port gives the bench visibility.

---
 rtl/rtype_sequencer.sv | 176 +++++++++++++++++
 tb/tb_rtype_sequencer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type sequencer: owns the 32-entry register file and walks each
// accepted instruction through decode, execute and writeback on a 64-bit ALU.
module rtype_sequencer #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    input  logic             ld_en,
    input  logic [4:0]       ld_addr,
    input  logic [XLEN-1:0]  ld_data,
    input  logic [4:0]       dbg_addr,
    output logic [XLEN-1:0]  dbg_data,
    output logic             done_valid,
    output logic [4:0]       done_rd,
    output logic [XLEN-1:0]  done_result,
    output logic             err_illegal,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] retired,
    output logic             busy
);

    localparam int unsigned NREG   = 32;
    localparam logic [6:0]  OPC_OP = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    state_t          state;
    logic [31:0]     ir;
    alu_op_t         op;
    logic [XLEN-1:0] rf [NREG];
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] r;

    logic            dec_legal_c;
    alu_op_t         dec_op_c;
    logic [XLEN-1:0] sum_c;
    logic [XLEN-1:0] diff_c;
    logic [XLEN-1:0] alu_c;
    logic            ovf_c;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign rd  = ir[11:7];

    assign instr_ready = (state == IDLE) && !ld_en;
    assign busy        = (state != IDLE);
    // x0 is never written, so its entry stays zero
    assign dbg_data    = rf[dbg_addr];

    // Opcode/funct decode of the latched instruction
    always_comb begin
        dec_legal_c = 1'b0;
        dec_op_c    = ALU_ADD;
        if (ir[6:0] == OPC_OP) begin
            case ({ir[31:25], ir[14:12]})
                10'b0000000_000: begin dec_legal_c = 1'b1; dec_op_c = ALU_ADD; end
                10'b0100000_000: begin dec_legal_c = 1'b1; dec_op_c = ALU_SUB; end
                10'b0000000_111: begin dec_legal_c = 1'b1; dec_op_c = ALU_AND; end
                10'b0000000_110: begin dec_legal_c = 1'b1; dec_op_c = ALU_OR;  end
                10'b0000000_010: begin dec_legal_c = 1'b1; dec_op_c = ALU_SLT; end
                default: ;
            endcase
        end
    end

    // ALU; slt uses a true signed compare so it is immune to A-B overflow
    always_comb begin
        sum_c  = a + b;
        diff_c = a - b;
        alu_c  = '0;
        ovf_c  = 1'b0;
        case (op)
            ALU_ADD: begin
                alu_c = sum_c;
                ovf_c = (a[XLEN-1] == b[XLEN-1]) && (sum_c[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                alu_c = diff_c;
                ovf_c = (a[XLEN-1] != b[XLEN-1]) && (diff_c[XLEN-1] != a[XLEN-1]);
            end
            ALU_AND: alu_c = a & b;
            ALU_OR:  alu_c = a | b;
            ALU_SLT: alu_c = XLEN'($signed(a) < $signed(b));
            default: alu_c = '0;
        endcase
    end

    // Sequencer, register file and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ir          <= '0;
            op          <= ALU_ADD;
            a           <= '0;
            b           <= '0;
            r           <= '0;
            done_valid  <= 1'b0;
            done_rd     <= '0;
            done_result <= '0;
            err_illegal <= 1'b0;
            ovf_sticky  <= 1'b0;
            retired     <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            done_valid  <= 1'b0;
            err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_en) begin
                        if (ld_addr != 5'd0) begin
                            rf[ld_addr] <= ld_data;
                        end
                    end else if (instr_valid) begin
                        ir    <= instr;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_legal_c) begin
                        op    <= dec_op_c;
                        a     <= (rs1 == 5'd0) ? '0 : rf[rs1];
                        b     <= (rs2 == 5'd0) ? '0 : rf[rs2];
                        state <= EXEC;
                    end else begin
                        err_illegal <= 1'b1;
                        state       <= IDLE;
                    end
                end
                EXEC: begin
                    // Completion is registered here so it is visible throughout WB
                    r           <= alu_c;
                    done_valid  <= 1'b1;
                    done_rd     <= rd;
                    done_result <= alu_c;
                    if (ovf_c) begin
                        ovf_sticky <= 1'b1;
                    end
                    state <= WB;
                end
                WB: begin
                    if (rd != 5'd0) begin
                        rf[rd] <= r;
                    end
                    retired <= retired + CNT_W'(1);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Randomized scoreboard bench for rtype_sequencer: an architectural register
// model predicts each completion/illegal pulse, a monitor checks them as they appear.
module tb_rtype_sequencer;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             ld_en;
    logic [4:0]       ld_addr;
    logic [XLEN-1:0]  ld_data;
    logic [4:0]       dbg_addr;
    logic [XLEN-1:0]  dbg_data;
    logic             done_valid;
    logic [4:0]       done_rd;
    logic [XLEN-1:0]  done_result;
    logic             err_illegal;
    logic             ovf_sticky;
    logic [CNT_W-1:0] retired;
    logic             busy;

    rtype_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .done_valid(done_valid), .done_rd(done_rd), .done_result(done_result),
        .err_illegal(err_illegal), .ovf_sticky(ovf_sticky),
        .retired(retired), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        done_q[$];
    int          err_q[$];
    logic [63:0] mrf [32];
    bit          movf;
    int          mret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s: DUT did not respond within the cycle bound", what);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Architectural reference: what one instruction does to the register state
    function automatic void model(input logic [31:0] ins, output bit legal,
                                  output logic [4:0] rd, output logic [63:0] res,
                                  output bit ovf);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] wide;
        f7   = ins[31:25];
        f3   = ins[14:12];
        rd   = ins[11:7];
        a    = mrf[ins[19:15]];
        b    = mrf[ins[24:20]];
        res  = '0;
        ovf  = 1'b0;
        legal = (ins[6:0] == 7'h33) &&
                ((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2)) ||
                 (f7 == 7'h20 && f3 == 3'd0));
        if (legal) begin
            if (f7 == 7'h20) begin
                wide = {a[63], a} - {b[63], b};
                res  = wide[63:0];
                ovf  = (wide[64] != wide[63]);
            end else if (f3 == 3'd0) begin
                wide = {a[63], a} + {b[63], b};
                res  = wide[63:0];
                ovf  = (wide[64] != wide[63]);
            end else if (f3 == 3'd7) begin
                res = a & b;
            end else if (f3 == 3'd6) begin
                res = a | b;
            end else begin
                res = ((a[63] && !b[63]) || (a[63] == b[63] && a < b)) ? 64'd1 : 64'd0;
            end
        end
    endfunction

    // Scoreboard monitor: compares pulses against predictions at the falling edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (done_valid) begin
                chk("done_expected", 64'(done_q.size() != 0), 64'd1);
                if (done_q.size() != 0) begin
                    e = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("done_rd", 64'(done_rd), 64'(e.rd));
                    chk("done_result", done_result, e.res);
                end
            end else if (done_q.size() != 0 && cyc > done_q[0].cyc) begin
                chk("done_missing", 64'(done_valid), 64'd1);
                void'(done_q.pop_front());
            end
            if (err_illegal) begin
                chk("err_expected", 64'(err_q.size() != 0), 64'd1);
                if (err_q.size() != 0) begin
                    chk("err_cycle", 64'(cyc), 64'(err_q.pop_front()));
                end
            end else if (err_q.size() != 0 && cyc > err_q[0]) begin
                chk("err_missing", 64'(err_illegal), 64'd1);
                void'(err_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy) begin
            @(negedge clk);
            n++;
            if (n > 20) timeout_fail("wait_idle");
        end
    endtask

    task automatic preload(input logic [4:0] addr, input logic [63:0] data);
        wait_idle();
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        if (addr != 5'd0) mrf[addr] = data;
    endtask

    task automatic send(input logic [31:0] ins, input bit keep, output int acc);
        int          n;
        bit          legal;
        bit          ovf;
        logic [4:0]  rd;
        logic [63:0] res;
        instr       = ins;
        instr_valid = 1'b1;
        #1;
        n = 0;
        while (!instr_ready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 20) timeout_fail("instr_ready");
        end
        @(posedge clk);
        #1;
        acc = cyc;
        model(ins, legal, rd, res, ovf);
        if (legal) begin
            done_q.push_back('{rd, res, acc + 2});
            if (rd != 5'd0) mrf[rd] = res;
            if (ovf) movf = 1'b1;
            mret++;
        end else begin
            err_q.push_back(acc + 1);
        end
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic check_reg(input logic [4:0] addr, input string name);
        dbg_addr = addr;
        #1;
        chk(name, dbg_data, mrf[addr]);
    endtask

    task automatic check_reg_val(input logic [4:0] addr, input string name, input logic [63:0] exp);
        dbg_addr = addr;
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic check_status();
        chk("retired", 64'(retired), 64'(mret % (1 << CNT_W)));
        chk("ovf_sticky", 64'(ovf_sticky), 64'(movf));
    endtask

    function automatic logic [63:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [31:0] pick_instr();
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [6:0] opc;
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 8))
            0: return rtype(7'h00, rs2, rs1, 3'd0, rd);
            1: return rtype(7'h20, rs2, rs1, 3'd0, rd);
            2: return rtype(7'h00, rs2, rs1, 3'd7, rd);
            3: return rtype(7'h00, rs2, rs1, 3'd6, rd);
            4: return rtype(7'h00, rs2, rs1, 3'd2, rd);
            5: return rtype(7'h01, rs2, rs1, 3'($urandom_range(0, 7)), rd);
            6: return rtype(7'h20, rs2, rs1, 3'($urandom_range(1, 7)), rd);
            7: return rtype(7'h00, rs2, rs1, 3'($urandom_range(3, 5)), rd);
            default: begin
                opc = 7'($urandom);
                if (opc == 7'h33) opc = 7'h13;
                return {7'h00, rs2, rs1, 3'd0, rd, opc};
            end
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int acc3;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        dbg_addr    = '0;
        movf        = 1'b0;
        mret        = 0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        #1;
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_err_illegal", 64'(err_illegal), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_rd", 64'(done_rd), 64'd0);
        chk("rst_done_result", done_result, 64'd0);
        chk("rst_instr_ready", 64'(instr_ready), 64'd1);
        check_status();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic add
        preload(5'd5, 64'd5);
        preload(5'd6, 64'd6);
        send(32'h006283B3, 1'b0, acc);
        wait_idle();
        check_reg_val(5'd7, "t1_x7", 64'd11);
        chk("t1_retired", 64'(retired), 64'd1);

        // Sub and slt around all-ones
        preload(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        send(rtype(7'h20, 5'd1, 5'd0, 3'd0, 5'd2), 1'b0, acc);
        wait_idle();
        send(rtype(7'h00, 5'd0, 5'd1, 3'd2, 5'd3), 1'b0, acc);
        wait_idle();
        send(rtype(7'h00, 5'd1, 5'd0, 3'd2, 5'd4), 1'b0, acc);
        wait_idle();
        check_reg_val(5'd2, "t2_x2", 64'd1);
        check_reg_val(5'd3, "t2_x3", 64'd1);
        check_reg_val(5'd4, "t2_x4", 64'd0);
        chk("t2_no_ovf", 64'(ovf_sticky), 64'd0);

        // Overflow is sticky
        preload(5'd8, 64'h7FFF_FFFF_FFFF_FFFF);
        preload(5'd9, 64'd1);
        send(rtype(7'h00, 5'd9, 5'd8, 3'd0, 5'd10), 1'b0, acc);
        wait_idle();
        check_reg_val(5'd10, "t3_x10", 64'h8000_0000_0000_0000);
        chk("t3_ovf_set", 64'(ovf_sticky), 64'd1);
        send(rtype(7'h00, 5'd9, 5'd8, 3'd7, 5'd11), 1'b0, acc);
        wait_idle();
        chk("t3_ovf_held", 64'(ovf_sticky), 64'd1);

        // Illegal opcode, then write to x0
        send({7'h00, 5'd6, 5'd5, 3'd0, 5'd7, 7'b0010011}, 1'b0, acc);
        wait_idle();
        chk("t4_retired_unchanged", 64'(retired), 64'd6);
        send(rtype(7'h00, 5'd6, 5'd5, 3'd6, 5'd0), 1'b0, acc);
        wait_idle();
        chk("t4_done_result", done_result, 64'd7);
        check_reg_val(5'd0, "t4_x0", 64'd0);
        check_status();

        // Continuous valid: one acceptance every fourth edge
        send(rtype(7'h00, 5'd6, 5'd5, 3'd0, 5'd12), 1'b1, acc);
        send(rtype(7'h20, 5'd12, 5'd5, 3'd0, 5'd13), 1'b1, acc2);
        send(rtype(7'h00, 5'd13, 5'd12, 3'd6, 5'd14), 1'b0, acc3);
        chk("b2b_gap1", 64'(acc2 - acc), 64'd4);
        chk("b2b_gap2", 64'(acc3 - acc2), 64'd4);
        wait_idle();
        check_reg(5'd14, "b2b_x14");

        // Preload in IDLE wins over the handshake
        ld_en       = 1'b1;
        ld_addr     = 5'd15;
        ld_data     = 64'hDEAD_BEEF_0123_4567;
        instr       = rtype(7'h00, 5'd6, 5'd5, 3'd0, 5'd16);
        instr_valid = 1'b1;
        #1;
        chk("ld_blocks_ready", 64'(instr_ready), 64'd0);
        @(posedge clk);
        #1;
        ld_en       = 1'b0;
        instr_valid = 1'b0;
        mrf[15]     = 64'hDEAD_BEEF_0123_4567;
        chk("ld_not_accepted", 64'(busy), 64'd0);
        check_reg(5'd15, "ld_x15");

        // Preload while busy is ignored
        send(rtype(7'h00, 5'd6, 5'd5, 3'd7, 5'd17), 1'b0, acc);
        ld_en   = 1'b1;
        ld_addr = 5'd5;
        ld_data = 64'h1234;
        #1;
        chk("busy_ready_low", 64'(instr_ready), 64'd0);
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        wait_idle();
        check_reg(5'd5, "busy_ld_x5");
        check_status();

        // Randomized traffic, exercising counter wrap
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) == 0) preload(5'($urandom_range(0, 31)), pick_val());
            send(pick_instr(), 1'b0, acc);
            if ($urandom_range(0, 3) == 0) begin
                ld_en   = 1'b1;
                ld_addr = 5'($urandom_range(1, 31));
                ld_data = pick_val();
                @(posedge clk);
                #1;
                ld_en = 1'b0;
            end
            wait_idle();
            check_status();
            check_reg(5'($urandom_range(0, 31)), "rand_reg");
        end
        for (int i = 0; i < 32; i++) check_reg(5'(i), "final_reg");

        // Reset while executing discards the instruction
        preload(5'd5, 64'd5);
        preload(5'd6, 64'd6);
        send(32'h006283B3, 1'b0, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        done_q.delete();
        err_q.delete();
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        movf = 1'b0;
        mret = 0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(instr_ready), 64'd1);
        check_reg_val(5'd7, "post_rst_x7", 64'd0);
        check_reg_val(5'd5, "post_rst_x5", 64'd0);
        check_status();
        repeat (4) @(negedge clk);
        chk("post_rst_idle", 64'(busy), 64'd0);

        chk("pending_done", 64'(done_q.size()), 64'd0);
        chk("pending_err", 64'(err_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
